// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: shadows EX/MEM/WB destinations
// to produce load-use stalls, redirect flushes, data-memory freezes and EX forwarding.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic [1:0]       id_memtoreg,
  input  logic             id_memop,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_busy,
  output logic [CNT_W-1:0] cnt_lduse,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
    logic       memop;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } shadow_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  shadow_t     ex_r;
  shadow_t     mem_r;
  shadow_t     wb_r;
  shadow_t     id_entry_s;
  wait_state_t state_r;
  logic        mem_busy_r;
  logic        lduse_s;
  logic        freeze_s;
  logic        flush_s;
  logic        stall_s;
  logic        advance_id_s;
  logic [1:0]  fwd_a_s;
  logic [1:0]  fwd_b_s;
  logic [CNT_W-1:0] cnt_lduse_r;
  logic [CNT_W-1:0] cnt_flush_r;
  logic [CNT_W-1:0] cnt_freeze_r;
  logic        unused_s;

  // A producer stage can feed an EX source only if it really writes a non-x0 register.
  function automatic logic fwd_hit(input shadow_t src, input logic [4:0] rs, input logic use_rs);
    return src.valid & src.regwrite & (src.rd != 5'd0) & (src.rd == rs) & use_rs;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Hazard detection with priority freeze > redirect > load-use.
  always_comb begin
    lduse_s  = id_valid & ex_r.valid & ex_r.is_load & (ex_r.rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_r.rd)) | (id_use_rs2 & (id_rs2 == ex_r.rd)));
    freeze_s = mem_r.valid & mem_r.memop & ~dmem_ready;
    flush_s  = ex_redirect & ~freeze_s;
    stall_s  = lduse_s & ~ex_redirect & ~freeze_s;
    advance_id_s = id_valid & ~flush_s & ~stall_s;
  end

  // Shadow image of the instruction currently in ID.
  always_comb begin
    id_entry_s          = '0;
    id_entry_s.valid    = 1'b1;
    id_entry_s.rd       = id_rd;
    id_entry_s.regwrite = id_regwrite;
    id_entry_s.is_load  = (id_memtoreg == 2'b01);
    id_entry_s.memop    = id_memop;
    id_entry_s.rs1      = id_rs1;
    id_entry_s.rs2      = id_rs2;
    id_entry_s.use_rs1  = id_use_rs1;
    id_entry_s.use_rs2  = id_use_rs2;
  end

  // Forwarding selects for the instruction in EX; MEM is younger so it wins over WB.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (ex_r.valid) begin
      if (fwd_hit(mem_r, ex_r.rs1, ex_r.use_rs1)) begin
        fwd_a_s = 2'b01;
      end else if (fwd_hit(wb_r, ex_r.rs1, ex_r.use_rs1)) begin
        fwd_a_s = 2'b10;
      end else begin
        fwd_a_s = 2'b00;
      end
      if (fwd_hit(mem_r, ex_r.rs2, ex_r.use_rs2)) begin
        fwd_b_s = 2'b01;
      end else if (fwd_hit(wb_r, ex_r.rs2, ex_r.use_rs2)) begin
        fwd_b_s = 2'b10;
      end else begin
        fwd_b_s = 2'b00;
      end
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Shadow pipeline: frozen as a whole, otherwise shifts with a bubble on stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (freeze_s) begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (advance_id_s) begin
        ex_r <= id_entry_s;
      end else begin
        ex_r <= '0;
      end
    end
  end

  // Data-memory wait FSM; mem_busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      mem_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (freeze_s) begin
            state_r    <= ST_WAIT;
            mem_busy_r <= 1'b1;
          end else begin
            state_r    <= ST_RUN;
            mem_busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state_r    <= ST_RUN;
            mem_busy_r <= 1'b0;
          end else begin
            state_r    <= ST_WAIT;
            mem_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          mem_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating lost-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lduse_r  <= '0;
      cnt_flush_r  <= '0;
      cnt_freeze_r <= '0;
    end else begin
      cnt_lduse_r  <= sat_inc(cnt_lduse_r, stall_s);
      cnt_flush_r  <= sat_inc(cnt_flush_r, flush_s);
      cnt_freeze_r <= sat_inc(cnt_freeze_r, freeze_s);
    end
  end

  // WB only needs its destination fields; the rest of the entry is carried for symmetry.
  assign unused_s = ^wb_r;

  assign stall_if   = stall_s;
  assign stall_id   = stall_s;
  assign flush_if   = flush_s;
  assign flush_id   = flush_s;
  assign freeze     = freeze_s;
  assign fwd_a      = fwd_a_s;
  assign fwd_b      = fwd_b_s;
  assign mem_busy   = mem_busy_r;
  assign cnt_lduse  = cnt_lduse_r;
  assign cnt_flush  = cnt_flush_r;
  assign cnt_freeze = cnt_freeze_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core. Sits beside the decode stage.
- Keeps a shadow scoreboard of in-flight destination registers in EX/MEM/WB.
- From it, generates load-use stalls, taken-branch flushes, data-memory wait freezes and EX-operand forwarding selects.
- Also keeps saturating performance counters of lost cycles.

Parameters:
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  5  ID destination (RD_ID)
id_regwrite  in  1  RegWrite_ID
id_memtoreg  in  2  MemtoReg_ID; 01 marks a load
id_memop  in  1  ID instruction is a load or store
ex_redirect  in  1  EX resolved a taken branch or jump (PC_E and condition true)
dmem_ready  in  1  data memory completes the MEM-stage access this cycle
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID/EX source fields; insert bubble into EX
flush_if  out  1  clear IF/ID to NOP
flush_id  out  1  clear ID/EX to NOP
freeze  out  1  hold every pipeline register
fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB write data
fwd_b  out  2  EX operand B source, same encoding
mem_busy  out  1  wait FSM in WAIT
cnt_lduse  out  CNT_W  load-use stall cycles
cnt_flush  out  CNT_W  redirect events
cnt_freeze  out  CNT_W  freeze cycles

Behaviour:
- Shadow entries EX, MEM, WB: each holds {valid, rd, regwrite, is_load, memop, rs1, rs2, use_rs1, use_rs2}. All cleared to invalid on reset.
- Raw conditions (combinational):
  - lduse = id_valid & EX.valid & EX.is_load & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
  - freeze = MEM.valid & MEM.memop & !dmem_ready.
- Priority is freeze > redirect > lduse:
  - flush_if = flush_id = ex_redirect & !freeze.
  - stall_if = stall_id = lduse & !ex_redirect & !freeze.
- Shadow update per clock:
  - freeze: hold all entries.
  - Otherwise WB<=MEM and MEM<=EX.
  - EX<=ID fields only if id_valid & !flush_id & !stall_id; else EX.valid<=0.
- fwd_a (combinational, from the registered EX entry): 01 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.use_rs1; else 10 if the same test passes against WB; else 00. MEM has precedence over WB. fwd_b is identical using rs2. Both are 00 when EX is invalid.
- Wait FSM, states RUN and WAIT:
  - RUN->WAIT when freeze.
  - WAIT->RUN in the cycle dmem_ready=1; that cycle advances normally.
  - mem_busy=1 in WAIT.
- Counters:
  - cnt_lduse increments on each cycle stall_id=1.
  - cnt_flush increments on each cycle flush_id=1.
  - cnt_freeze increments on each cycle freeze=1.
  - All saturate at all-ones; no wrap.
- Reset (asynchronous, any time including mid-WAIT):
  - State RUN; all shadow entries invalid; counters 0.
  - All outputs then evaluate to 0 because every entry is invalid.
- Latency:
  - stall/flush/freeze are same-cycle combinational.
  - A load-use stall lasts exactly 1 cycle.
  - A redirect produces exactly 2 squashed slots: IF/ID and ID/EX.
- A redirect held during freeze remains in EX. Its flush asserts in the first non-frozen cycle.

Test Plan:
- lw x5 then add x6,x5,x7 back-to-back -> stall_if=stall_id=1 for 1 cycle, then fwd_a=10 for the add in EX; cnt_lduse=1.
- add x5 then sub x8,x5,x5 -> no stall; fwd_a=fwd_b=01 with sub in EX. A third op reading x5 two slots later -> fwd=10. Writes to x0 never forward.
- ex_redirect=1 together with a load-use condition -> flush_if=flush_id=1, stall=0, EX bubble next cycle; cnt_flush=1, cnt_lduse=0.
- sw in MEM with dmem_ready low for 3 cycles -> freeze=1 for 3 cycles, mem_busy=1 from the 2nd cycle, shadow unchanged, cnt_freeze=3; advance on the ready cycle.
- Redirect in EX during a 2-cycle freeze -> flush asserted only in the cycle after release, exactly once.
- rst_n pulled low while in WAIT -> all outputs 0 and counters 0 immediately; first instruction after release flows with no stall. Counters forced to all-ones stay at all-ones on further events.
